vol_agc_scheduler: RTL and testbench

Automatic-gain scheduler that drives the volume shift stage. It counts clipped samples over a fixed power-of-two window of valid audio samples and converts the count to a fixed-point clips-per-unit value `cpc`. It publishes `cpc` once per window and qualifies it with `cpc_en`. Downstream, the shift stage turns `cpc`/`cpc_en` into a right-shift, a left-shift or a pass-through of the volume word.

---
 rtl/vol_agc_scheduler.sv | 137 +++++++++++++
 tb/tb_vol_agc_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vol_agc_scheduler.sv
// vol_agc_scheduler
//   Counts clipped audio samples over a fixed 2^WIN_LOG2 window of valid
//   samples. At each window end it converts the count to a saturated
//   fixed-point clips-per-unit value and publishes it as cpc.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   agc_en       enable measurement/publication; low aborts and clears
//   hold         freeze published cpc (measurement continues)
//   sample_valid sample qualifier, at most one sample per cycle
//   sample       signed audio sample, VOL_BITS wide
//   cpc          published clips-per-unit, Q(CPC_BITS-NUM_DECIMAL).NUM_DECIMAL
//   cpc_en       cpc valid (after the first complete window)
//   cpc_update   one-cycle pulse when a new window value is published
module vol_agc_scheduler #(
    parameter int VOL_BITS    = 23,
    parameter int CPC_BITS    = 15,
    parameter int NUM_DECIMAL = 8,
    parameter int WIN_LOG2    = 10,
    parameter int UNIT_LOG2   = 8,
    parameter int CLIP_THRESH = 4063232
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       agc_en,
    input  logic                       hold,
    input  logic                       sample_valid,
    input  logic signed [VOL_BITS-1:0] sample,
    output logic        [CPC_BITS-1:0] cpc,
    output logic                       cpc_en,
    output logic                       cpc_update
);

    localparam int SHIFT = NUM_DECIMAL + UNIT_LOG2 - WIN_LOG2;
    localparam int CNT_W = WIN_LOG2 + 1;
    // Raw width always exceeds CPC_BITS so the saturation compare is meaningful.
    localparam int RAW_W = (CNT_W + SHIFT > CPC_BITS) ? CNT_W + SHIFT : CPC_BITS + 1;

    localparam logic signed [VOL_BITS-1:0] THR_POS = VOL_BITS'(CLIP_THRESH);
    localparam logic signed [VOL_BITS-1:0] THR_NEG = VOL_BITS'(-CLIP_THRESH);
    localparam logic [RAW_W-1:0] CPC_MAX = {{(RAW_W-CPC_BITS){1'b0}}, {CPC_BITS{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WIN_LOG2-1:0]   win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]      clip_cnt_q, clip_cnt_d;
    logic [CPC_BITS-1:0]   cpc_q, cpc_d;
    logic                  cpc_en_q, cpc_en_d;
    logic                  cpc_update_q, cpc_update_d;

    logic                  clip;
    logic                  win_end;
    logic [CNT_W-1:0]      final_count;
    logic [RAW_W-1:0]      cpc_raw;
    logic [CPC_BITS-1:0]   cpc_sat;

    // Signed compare: the most-negative code falls below THR_NEG and counts.
    assign clip        = sample_valid && ((sample >= THR_POS) || (sample <= THR_NEG));
    assign win_end     = sample_valid && (win_cnt_q == '1);
    // The completing sample is included in the window total.
    assign final_count = clip_cnt_q + CNT_W'(clip);
    assign cpc_raw     = RAW_W'(final_count) << SHIFT;
    assign cpc_sat     = (cpc_raw > CPC_MAX) ? '1 : cpc_raw[CPC_BITS-1:0];

    always_comb begin
        state_d      = state_q;
        win_cnt_d    = win_cnt_q;
        clip_cnt_d   = clip_cnt_q;
        cpc_d        = cpc_q;
        cpc_en_d     = cpc_en_q;
        cpc_update_d = 1'b0;

        if (!agc_en) begin
            // Disable dominates a coincident window end: no publication.
            state_d    = S_IDLE;
            win_cnt_d  = '0;
            clip_cnt_d = '0;
            cpc_d      = '0;
            cpc_en_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // Sample in the enabling cycle is ignored.
                    state_d = S_FIRST;
                end
                S_FIRST, S_RUN: begin
                    if (sample_valid) begin
                        win_cnt_d = win_cnt_q + WIN_LOG2'(1);
                        if (win_end) begin
                            clip_cnt_d = '0;
                            state_d    = S_RUN;
                            cpc_en_d   = 1'b1;
                            if (!hold) begin
                                cpc_d        = cpc_sat;
                                cpc_update_d = 1'b1;
                            end
                        end else begin
                            clip_cnt_d = final_count;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            win_cnt_q    <= '0;
            clip_cnt_q   <= '0;
            cpc_q        <= '0;
            cpc_en_q     <= 1'b0;
            cpc_update_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            clip_cnt_q   <= clip_cnt_d;
            cpc_q        <= cpc_d;
            cpc_en_q     <= cpc_en_d;
            cpc_update_q <= cpc_update_d;
        end
    end

    assign cpc        = cpc_q;
    assign cpc_en     = cpc_en_q;
    assign cpc_update = cpc_update_q;

endmodule

// File: tb/tb_vol_agc_scheduler.sv
// Testbench for vol_agc_scheduler: directed scenarios followed by random
// traffic, checked against a window-level reference model and a publication
// scoreboard.
module tb_vol_agc_scheduler;

    localparam int THR = 4063232;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               agc_en;
    logic               hold;
    logic               sample_valid;
    logic signed [22:0] sample;
    logic [14:0]        cpc;
    logic               cpc_en;
    logic               cpc_update;

    vol_agc_scheduler #(
        .VOL_BITS(23), .CPC_BITS(15), .NUM_DECIMAL(8),
        .WIN_LOG2(10), .UNIT_LOG2(8), .CLIP_THRESH(THR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .agc_en(agc_en), .hold(hold),
        .sample_valid(sample_valid), .sample(sample),
        .cpc(cpc), .cpc_en(cpc_en), .cpc_update(cpc_update)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // measuring: 0 = disabled/just reset, 1 = counting samples
    int measuring = 0;
    int n_in_win  = 0;
    int n_clips   = 0;
    int exp_cpc   = 0;
    int exp_en    = 0;
    int exp_pulse = 0;
    int cycle     = 0;
    int exp_q[$];

    always @(posedge clk) begin
        int s;
        int raw;
        cycle++;
        exp_pulse = 0;
        if (!rst_n || !agc_en) begin
            measuring = 0; n_in_win = 0; n_clips = 0;
            exp_cpc = 0; exp_en = 0;
        end else if (measuring == 0) begin
            measuring = 1;
        end else if (sample_valid) begin
            s = int'(sample);
            if (s >= THR || s <= -THR) n_clips++;
            n_in_win++;
            if (n_in_win == 1024) begin
                // clips per 256 samples in Q.8 -> clips * 256 * 256 / 1024
                raw = n_clips * 64;
                if (raw > 32767) raw = 32767;
                if (!hold) begin
                    exp_cpc = raw;
                    exp_pulse = 1;
                    exp_q.push_back(raw);
                end
                exp_en = 1;
                n_in_win = 0;
                n_clips = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    bit mon_on      = 0;
    int pulse_cnt   = 0;
    int last_cpc    = -1;
    int en_rise_cyc = -1;
    int prev_en     = 0;
    int pulse_cyc[$];

    always @(negedge clk) begin
        if (mon_on) begin
            chk("cpc", int'(cpc), exp_cpc);
            chk("cpc_en", int'(cpc_en), exp_en);
            chk("cpc_update", int'(cpc_update), exp_pulse);
            if (cpc_en && prev_en == 0) en_rise_cyc = cycle;
            prev_en = int'(cpc_en);
            if (cpc_update) begin
                pulse_cnt++;
                pulse_cyc.push_back(cycle);
                last_cpc = int'(cpc);
                if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
                else chk("published_cpc", int'(cpc), exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic signed [22:0] s);
        sample_valid = v;
        sample = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 23'sd0);
    endtask

    // count valid samples; those with index in [cf, ct) are THR, rest 0
    task automatic feed(input int count, input int cf, input int ct);
        for (int i = 0; i < count; i++)
            step(1'b1, (i >= cf && i < ct) ? 23'(THR) : 23'sd0);
    endtask

    function automatic logic signed [22:0] rnd_sample(input int pct);
        int v;
        int k;
        k = int'($urandom_range(3));
        if (int'($urandom_range(99)) < pct) begin
            case (k)
                0: v = THR;
                1: v = -THR;
                2: v = -4194304;
                default: v = THR + int'($urandom_range(131071));
            endcase
        end else begin
            case (k)
                0: v = 0;
                1: v = THR - 1;
                2: v = -(THR - 1);
                default: v = int'($urandom_range(2 * THR - 2)) - (THR - 1);
            endcase
        end
        return 23'(v);
    endfunction

    initial begin
        int pc;
        int diff;
        logic signed [22:0] edge_vals [5];
        edge_vals[0] = 23'sd4063231;
        edge_vals[1] = -23'sd4063231;
        edge_vals[2] = 23'sd4063232;
        edge_vals[3] = -23'sd4063232;
        edge_vals[4] = -23'sd4194304;

        rst_n = 1'b0; agc_en = 1'b0; hold = 1'b0;
        sample_valid = 1'b0; sample = '0;
        @(posedge clk); #1;
        mon_on = 1;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("reset_cpc", int'(cpc), 0);
        chk("reset_cpc_en", int'(cpc_en), 0);

        // Default window: 4 clips -> 1.0
        agc_en = 1'b1;
        step(1'b1, 23'(THR));                 // enabling cycle, ignored
        feed(1024, 0, 4);
        idle(2);
        chk("first_window_cpc", last_cpc, 256);
        chk("first_window_pulses", pulse_cnt, 1);
        chk("en_rise_with_pulse", en_rise_cyc, pulse_cyc[pulse_cyc.size()-1]);

        // Threshold edges: 3 qualifying samples -> 192
        for (int i = 0; i < 1024; i++)
            step(1'b1, (i < 5) ? edge_vals[i] : 23'sd0);
        idle(2);
        chk("threshold_cpc", last_cpc, 192);

        // Saturation then empty window
        feed(1024, 0, 1024);
        idle(2);
        chk("saturate_cpc", last_cpc, 32767);
        pc = pulse_cnt;
        feed(1024, 0, 0);
        idle(2);
        chk("zero_cpc", last_cpc, 0);
        chk("zero_pulse", pulse_cnt - pc, 1);

        // Back-to-back windows with valid held high
        feed(1024, 1023, 1024);
        feed(1024, 0, 1);
        idle(2);
        chk("b2b_cpc", last_cpc, 64);
        diff = pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2];
        chk("b2b_spacing", diff, 1024);

        // Hold
        feed(1024, 0, 4);
        idle(1);
        pc = pulse_cnt;
        hold = 1'b1;
        feed(1024, 0, 8);
        idle(2);
        chk("hold_cpc", int'(cpc), 256);
        chk("hold_no_pulse", pulse_cnt - pc, 0);
        hold = 1'b0;
        feed(1024, 0, 2);
        idle(2);
        chk("release_cpc", last_cpc, 128);

        // Abort via agc_en
        feed(500, 0, 4);
        agc_en = 1'b0;
        step(1'b1, 23'(THR));
        chk("abort_cpc", int'(cpc), 0);
        chk("abort_cpc_en", int'(cpc_en), 0);
        agc_en = 1'b1;
        step(1'b1, 23'(THR));
        feed(1023, 0, 4);
        idle(1);
        chk("abort_refill_en", int'(cpc_en), 0);
        feed(1, 1, 1);
        idle(1);
        chk("abort_refill_en_after", int'(cpc_en), 1);
        chk("abort_refill_cpc", int'(cpc), 256);

        // Abort via reset
        feed(500, 0, 8);
        rst_n = 1'b0;
        step(1'b1, 23'sd0);
        rst_n = 1'b1;
        chk("reset_mid_cpc", int'(cpc), 0);
        chk("reset_mid_cpc_en", int'(cpc_en), 0);
        step(1'b1, 23'(THR));
        feed(1023, 0, 4);
        idle(1);
        chk("reset_refill_en", int'(cpc_en), 0);
        feed(1, 1, 1);
        idle(1);
        chk("reset_refill_en_after", int'(cpc_en), 1);
        chk("reset_refill_cpc", int'(cpc), 256);

        // Random traffic
        begin
            int pct;
            pct = 5;
            for (int i = 0; i < 20000; i++) begin
                if ($urandom_range(1499) == 0) pct = int'($urandom_range(60));
                if ($urandom_range(2999) == 0) hold = ~hold;
                if ($urandom_range(3999) == 0) agc_en = 1'b0;
                else if (!agc_en && $urandom_range(9) == 0) agc_en = 1'b1;
                rst_n = ($urandom_range(6999) == 0) ? 1'b0 : 1'b1;
                step($urandom_range(3) != 0, rnd_sample(pct));
            end
            rst_n = 1'b1;
            hold = 1'b0;
            idle(3);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        mon_on = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
